// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 digest finalizer: the a..h
// working-state struct, the standard IV and the per-word feed-forward add.
package sha_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    localparam int DIGEST_W = 256;

    localparam HashState SHA256_IV = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    // Each word wraps on its own; no carry crosses a word boundary.
    function automatic HashState hash_add(input HashState x, input HashState y);
        HashState r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha_hit_holder.sv
// Single-entry holding register for winning nonces, drained by a valid/ready
// handshake, with a saturating counter of hits lost while it was full.
module sha_hit_holder
    import sha_pkg::*;
#(
    parameter int NONCE_W = 32,
    parameter int DROP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  HashState           digest_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [NONCE_W-1:0] nonce_o,
    output HashState           digest_o,
    output logic [DROP_W-1:0]  drop_count_o
);

    hold_state_e        state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    HashState           digest_q, digest_d;
    logic [DROP_W-1:0]  drop_q, drop_d;

    always_comb begin
        // NOTE: every target gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        nonce_d  = nonce_q;
        digest_d = digest_q;
        drop_d   = drop_q;
        unique case (state_q)
            HOLD_EMPTY: begin
                if (hit_i) begin
                    state_d  = HOLD_FULL;
                    nonce_d  = nonce_i;
                    digest_d = digest_i;
                end
            end
            HOLD_FULL: begin
                if (hit_i && ready_i) begin
                    nonce_d  = nonce_i;
                    digest_d = digest_i;
                end else if (hit_i) begin
                    if (drop_q != {DROP_W{1'b1}}) drop_d = drop_q + DROP_W'(1);
                end else if (ready_i) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the held nonce/digest are reset as well, so the outputs read 0 rather than X after reset.
            state_q  <= HOLD_EMPTY;
            nonce_q  <= '0;
            digest_q <= '0;
            drop_q   <= '0;
        end else begin
            // NOTE: non-blocking updates, so every register samples the pre-edge values.
            state_q  <= state_d;
            nonce_q  <= nonce_d;
            digest_q <= digest_d;
            drop_q   <= drop_d;
        end
    end

    assign valid_o      = (state_q == HOLD_FULL);
    assign nonce_o      = nonce_q;
    assign digest_o     = digest_q;
    assign drop_count_o = drop_q;

endmodule

// File: rtl/sha_digest_finalizer.sv
// Feed-forward add after the last SHA-256 round, digest-vs-target compare,
// winning-nonce capture and hash/drop statistics.
module sha_digest_finalizer
    import sha_pkg::*;
#(
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 32,
    parameter int DROP_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  HashState            state_i,
    input  logic [NONCE_W-1:0]  nonce_i,
    input  HashState            init_i,
    input  logic [DIGEST_W-1:0] target_i,
    output logic                digest_valid_o,
    output HashState            digest_o,
    output logic                found_valid_o,
    input  logic                found_ready_i,
    output logic [NONCE_W-1:0]  found_nonce_o,
    output HashState            found_digest_o,
    output logic [CNT_W-1:0]    hashes_checked_o,
    output logic [DROP_W-1:0]   drop_count_o
);

    logic                s1_valid_q, s1_valid_d;
    HashState            s1_digest_q, s1_digest_d;
    logic [NONCE_W-1:0]  s1_nonce_q, s1_nonce_d;
    logic [CNT_W-1:0]    hashes_q, hashes_d;
    logic [DIGEST_W-1:0] cmp_value;
    logic                hit;

    always_comb begin
        s1_valid_d  = valid_i;
        s1_digest_d = hash_add(state_i, init_i);
        s1_nonce_d  = nonce_i;
    end

    // H7 is the most-significant word of the compare; words are not byte-swapped.
    always_comb begin
        cmp_value = {s1_digest_q.h, s1_digest_q.g, s1_digest_q.f, s1_digest_q.e,
                     s1_digest_q.d, s1_digest_q.c, s1_digest_q.b, s1_digest_q.a};
        hit       = s1_valid_q && (cmp_value <= target_i);
        hashes_d  = s1_valid_q ? hashes_q + CNT_W'(1) : hashes_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_digest_q <= '0;
            s1_nonce_q  <= '0;
            hashes_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_digest_q <= s1_digest_d;
            s1_nonce_q  <= s1_nonce_d;
            hashes_q    <= hashes_d;
        end
    end

    sha_hit_holder #(
        .NONCE_W (NONCE_W),
        .DROP_W  (DROP_W)
    ) u_holder (
        .clk          (clk),
        .rst_n        (rst_n),
        .hit_i        (hit),
        .nonce_i      (s1_nonce_q),
        .digest_i     (s1_digest_q),
        .ready_i      (found_ready_i),
        .valid_o      (found_valid_o),
        .nonce_o      (found_nonce_o),
        .digest_o     (found_digest_o),
        .drop_count_o (drop_count_o)
    );

    assign digest_valid_o   = s1_valid_q;
    assign digest_o         = s1_digest_q;
    assign hashes_checked_o = hashes_q;

endmodule

// File: doc/sha_digest_finalizer.md
Name: sha_digest_finalizer

Overview:
- Sits directly downstream of the last sha_standard_pipelined_stage in the unrolled 64-round SHA-256 pipeline.
- Adds the chaining value to the final round state (feed-forward add) and streams the 256-bit digest out.
- Compares the digest against a difficulty target and captures winning nonces in a holding register, handed off with a valid/ready handshake.
- Keeps a checked-hash counter and a dropped-hit counter.

Parameters:
- NONCE_W, 32, width of the nonce tag carried alongside each hash.
- CNT_W, 32, width of hashes_checked_o; wraps modulo 2^CNT_W.
- DROP_W, 16, width of drop_count_o; saturates at all-ones.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  state_i/nonce_i valid this cycle (aligned with the last pipeline stage output).
- state_i  input  HashState  final round state a..h.
- nonce_i  input  NONCE_W  nonce tag for state_i.
- init_i  input  HashState  chaining value H0..H7 (midstate or IV); quasi-static.
- target_i  input  256  difficulty target; H7 is the most-significant word of the compare.
- digest_valid_o  output  1  digest_o valid.
- digest_o  output  HashState  state + init, per word.
- found_valid_o  output  1  holding register occupied.
- found_ready_i  input  1  consumer accepts the hit.
- found_nonce_o  output  NONCE_W  nonce of the held hit.
- found_digest_o  output  HashState  digest of the held hit.
- hashes_checked_o  output  CNT_W  compares performed.
- drop_count_o  output  DROP_W  hits lost because the holding register was full.

Behaviour:
- Reset (async assert, sync deassert on rst_n rising at clk): every valid is 0, every data register is 0, all counters are 0.
- Stage 1, latency 1: digest word i = state word i + init word i, mod 2^32 with no carry between words (a+H0 … h+H7). Registered with valid and nonce. digest_valid_o/digest_o are the stage-1 registers.
- Stage 2, latency 2:
  - Form the 256-bit value {H7, H6, …, H0}, no byte swap inside words.
  - hit = stage-1 valid AND value <= target_i (unsigned), using target_i as sampled at that edge.
  - hashes_checked_o increments by 1 on every stage-1 valid, wrapping.
- Holding register, states EMPTY / FULL:
  - EMPTY + hit → FULL; load nonce and digest; found_valid_o rises 2 cycles after valid_i.
  - FULL + found_ready_i, no hit → EMPTY.
  - FULL + found_ready_i + hit in the same cycle → stays FULL, loads the new hit; no drop.
  - FULL + no found_ready_i + hit → stays FULL, old contents kept, new hit discarded; drop_count_o += 1, saturating at 2^DROP_W−1.
  - found_nonce_o/found_digest_o stay stable while found_valid_o=1 and found_ready_i=0.
  - found_ready_i while EMPTY is ignored.
- valid_i may be asserted every cycle (throughput 1/clk). Data lanes are don't-care when valid_i=0 and must not cause hits or count.
- Reset mid-operation: in-flight hashes and the held hit are discarded; counters are cleared.

Decomposition:
- Package sha_pkg holds:
  - typedef HashState, a packed struct a,b,c,d,e,f,g,h of logic[31:0], a first;
  - localparam SHA256_IV, a HashState constant;
  - localparam DIGEST_W = 256.
- One sub-module, sha_hit_holder: the EMPTY/FULL holding register plus saturating drop counter.
- The adder and the comparator stay inline.

Test Plan:
- Wrap add: state_i all words 0x00000001, init_i all 0xFFFFFFFF, valid_i one cycle → next cycle digest_valid_o=1, digest_o all 0x00000000. With target_i all-ones → found_valid_o=1 at +2 with that nonce; hashes_checked_o=1.
- Boundary compare: digest set exactly equal to target_i=0x00000000_FFFF0000_0…0 (H7 MS) → hit. Digest = target+1 in H0 → no hit. Counters 2, found stays 0 for the second hash.
- Back-pressure: found_ready_i=0, three consecutive hits with nonces 5, 6, 7 → found_nonce_o stays 5, drop_count_o=2. Then ready=1 for one cycle, no new hit → found_valid_o falls.
- Simultaneous drain+load: FULL with nonce 10, found_ready_i=1 in the same cycle a hit with nonce 11 reaches stage 2 → next cycle found_valid_o=1, nonce 11, drop_count_o unchanged.
- Saturation/wrap: force drop_count_o to 0xFFFF via repeated dropped hits (or DROP_W=2 variant: 5 drops → 3). hashes_checked_o with CNT_W=4 after 17 valids → 1.
- Reset mid-stream: streaming valid_i with FULL holder, pulse rst_n low asynchronously between edges → all outputs 0 immediately; no stale digest_valid_o after release.
